// File: rtl/sensor_avg_alarm.sv
// Moving-average conditioner for the 1 MHz sensor stream: averages the last
// 2^LOG2_WIN samples, drives SAFE/DANGER with hysteresis and flags a silent sensor.
module sensor_avg_alarm #(
  parameter int         LOG2_WIN  = 2,
  parameter logic [7:0] TH_HI     = 8'd105,
  parameter logic [7:0] TH_LO     = 8'd95,
  parameter int         STALE_CYC = 2000000
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  output logic       win_full,
  output logic       state_safe,
  output logic       alarm_change,
  output logic       stale
);

  localparam int W      = 1 << LOG2_WIN;
  localparam int SUM_W  = 8 + LOG2_WIN;
  localparam int PTR_W  = (LOG2_WIN > 0) ? LOG2_WIN : 1;
  localparam int FILL_W = LOG2_WIN + 1;
  localparam int IDLE_W = $clog2(STALE_CYC + 1);

  typedef enum logic [1:0] {S_INIT, S_SAFE, S_DANGER} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_alarm_next;
  logic [W*8-1:0]     w_buf_flat;
  logic [7:0]         w_old;
  logic [SUM_W-1:0]   r_sum;
  logic [SUM_W-1:0]   w_sum_next;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [FILL_W-1:0]  r_fill;
  logic [FILL_W-1:0]  w_fill_next;
  logic [IDLE_W-1:0]  r_idle;
  logic [7:0]         r_avg_out;
  logic               r_avg_valid;
  logic               r_win_full;
  logic               r_alarm_change;
  logic               r_stale;
  logic               w_flush;

  // A sample arriving on the trigger cycle wins over the flush.
  assign w_flush = !valid_in && (r_idle == IDLE_W'(STALE_CYC));

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_buf
      logic [7:0] r_entry;
      always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
          r_entry <= '0;
        end else if (valid_in && (r_wr_ptr == PTR_W'(gi))) begin
          r_entry <= data_in;
        end else if (w_flush) begin
          r_entry <= '0;
        end
      end
      assign w_buf_flat[gi*8 +: 8] = r_entry;
    end
  endgenerate

  assign w_old       = w_buf_flat[{r_wr_ptr, 3'b000} +: 8];
  assign w_sum_next  = r_sum + SUM_W'(data_in) - SUM_W'(w_old);
  assign w_ptr_next  = (r_wr_ptr == PTR_W'(W - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_fill_next = (r_fill == FILL_W'(W)) ? r_fill : r_fill + 1'b1;

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      r_sum          <= '0;
      r_wr_ptr       <= '0;
      r_fill         <= '0;
      r_idle         <= '0;
      r_avg_out      <= '0;
      r_avg_valid    <= 1'b0;
      r_win_full     <= 1'b0;
      r_alarm_change <= 1'b0;
      r_stale        <= 1'b0;
    end else begin
      r_avg_valid    <= 1'b0;
      r_alarm_change <= w_alarm_next;
      if (valid_in) begin
        r_sum       <= w_sum_next;
        r_wr_ptr    <= w_ptr_next;
        r_fill      <= w_fill_next;
        r_avg_out   <= w_sum_next[SUM_W-1:LOG2_WIN];
        r_avg_valid <= 1'b1;
        r_win_full  <= (w_fill_next == FILL_W'(W));
        r_stale     <= 1'b0;
      end else if (w_flush) begin
        // avg_out deliberately holds its last value while stale
        r_sum      <= '0;
        r_wr_ptr   <= '0;
        r_fill     <= '0;
        r_win_full <= 1'b0;
        r_stale    <= 1'b1;
      end
      if (valid_in) begin
        r_idle <= '0;
      end else if (r_idle != IDLE_W'(STALE_CYC)) begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_alarm_next = 1'b0;
    if (w_flush) begin
      w_state_next = S_INIT;
    end else if (r_avg_valid && r_win_full) begin
      case (r_state)
        S_INIT: begin
          w_state_next = (r_avg_out >= TH_HI) ? S_SAFE : S_DANGER;
        end
        S_SAFE: begin
          if (r_avg_out <= TH_LO) begin
            w_state_next = S_DANGER;
            w_alarm_next = 1'b1;
          end
        end
        S_DANGER: begin
          if (r_avg_out >= TH_HI) begin
            w_state_next = S_SAFE;
            w_alarm_next = 1'b1;
          end
        end
        default: w_state_next = S_INIT;
      endcase
    end
  end

  assign avg_out      = r_avg_out;
  assign avg_valid    = r_avg_valid;
  assign win_full     = r_win_full;
  assign state_safe   = (r_state == S_SAFE);
  assign alarm_change = r_alarm_change;
  assign stale        = r_stale;

endmodule

// File: tb/tb_sensor_avg_alarm.sv
// Directed bench for sensor_avg_alarm: table of spaced samples with hand-computed
// averages/states, plus sequences for back-to-back, stale, collision and async reset.
module tb_sensor_avg_alarm;

  logic       clk_1MHz;
  logic       rst;
  logic       valid_in;
  logic [7:0] data_in;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       win_full;
  logic       state_safe;
  logic       alarm_change;
  logic       stale;

  int n_vec;
  int n_err;

  sensor_avg_alarm #(
    .LOG2_WIN (2),
    .TH_HI    (8'd105),
    .TH_LO    (8'd95),
    .STALE_CYC(50)
  ) dut (
    .clk_1MHz    (clk_1MHz),
    .rst         (rst),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .win_full    (win_full),
    .state_safe  (state_safe),
    .alarm_change(alarm_change),
    .stale       (stale)
  );

  initial clk_1MHz = 1'b0;
  always #5 clk_1MHz = ~clk_1MHz;

  typedef struct {
    logic       rst_before;
    logic [7:0] data;
    logic [7:0] exp_avg;
    logic       exp_full;
    logic       exp_safe;
    logic       exp_chg;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic [7:0] a,
                              input logic f, input logic s, input logic c);
    vec_t v;
    v.rst_before = r;
    v.data       = d;
    v.exp_avg    = a;
    v.exp_full   = f;
    v.exp_safe   = s;
    v.exp_chg    = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic do_reset(input logic check_outputs);
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'd0;
    #1;
    if (check_outputs) begin
      check("reset avg_out", avg_out, 0);
      check("reset avg_valid", avg_valid, 0);
      check("reset win_full", win_full, 0);
      check("reset state_safe", state_safe, 0);
      check("reset alarm_change", alarm_change, 0);
      check("reset stale", stale, 0);
    end
    @(negedge clk_1MHz);
    rst = 1'b0;
  endtask

  task automatic apply_sample(input logic [7:0] d, input logic [7:0] exp_avg,
                              input logic exp_full, input logic exp_safe,
                              input logic exp_chg, input string tag);
    valid_in = 1'b1;
    data_in  = d;
    @(negedge clk_1MHz);
    valid_in = 1'b0;
    check({tag, " avg_out"}, avg_out, exp_avg);
    check({tag, " avg_valid"}, avg_valid, 1);
    check({tag, " win_full"}, win_full, exp_full);
    check({tag, " stale"}, stale, 0);
    @(negedge clk_1MHz);
    check({tag, " state_safe"}, state_safe, exp_safe);
    check({tag, " alarm_change"}, alarm_change, exp_chg);
    check({tag, " avg_valid drop"}, avg_valid, 0);
    @(negedge clk_1MHz);
    check({tag, " alarm_change drop"}, alarm_change, 0);
    $display("sample %s: data=%0d avg=%0d full=%0b safe=%0b", tag, d, avg_out, win_full, state_safe);
  endtask

  initial begin
    int exp3[9];
    n_vec = 0;
    n_err = 0;
    exp3  = '{0, 0, 1, 2, 3, 4, 5, 6, 7};

    // Fill + INIT->SAFE, then hysteresis walk from a 90s window.
    tbl[0]  = mk(1'b1, 8'd200, 8'd50,  1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 8'd200, 8'd150, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 8'd200, 8'd200, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 8'd90,  8'd22,  1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 8'd90,  8'd45,  1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 8'd90,  8'd67,  1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 8'd90,  8'd90,  1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 8'd100, 8'd92,  1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 8'd100, 8'd95,  1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 8'd100, 8'd97,  1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 8'd100, 8'd100, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 8'd104, 8'd101, 1'b1, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 8'd104, 8'd102, 1'b1, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 8'd104, 8'd103, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 8'd104, 8'd104, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 8'd110, 8'd105, 1'b1, 1'b1, 1'b1);
    tbl[17] = mk(1'b0, 8'd90,  8'd102, 1'b1, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 8'd90,  8'd98,  1'b1, 1'b1, 1'b0);
    tbl[19] = mk(1'b0, 8'd90,  8'd95,  1'b1, 1'b0, 1'b1);

    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'd0;
    @(negedge clk_1MHz);
    do_reset(1'b1);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst_before) do_reset(1'b0);
      apply_sample(tbl[i].data, tbl[i].exp_avg, tbl[i].exp_full, tbl[i].exp_safe,
                   tbl[i].exp_chg, $sformatf("tbl%0d", i));
      repeat (7) @(negedge clk_1MHz);
    end

    // Back-to-back 1..9: pointer wraps twice, one avg_valid per cycle.
    do_reset(1'b0);
    for (int n = 1; n <= 9; n++) begin
      valid_in = 1'b1;
      data_in  = 8'(n);
      @(negedge clk_1MHz);
      check($sformatf("b2b%0d avg_out", n), avg_out, exp3[n-1]);
      check($sformatf("b2b%0d avg_valid", n), avg_valid, 1);
      check($sformatf("b2b%0d win_full", n), win_full, (n >= 4) ? 1 : 0);
      check($sformatf("b2b%0d alarm_change", n), alarm_change, 0);
      $display("b2b sample %0d: avg=%0d", n, avg_out);
    end
    valid_in = 1'b0;
    @(negedge clk_1MHz);
    check("b2b avg_valid drop", avg_valid, 0);
    check("b2b state_safe", state_safe, 0);
    check("b2b alarm_change", alarm_change, 0);

    // Stale: SAFE window, then idle until the flush.
    do_reset(1'b0);
    apply_sample(8'd200, 8'd50,  1'b0, 1'b0, 1'b0, "pre_stale0");
    apply_sample(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, "pre_stale1");
    apply_sample(8'd200, 8'd150, 1'b0, 1'b0, 1'b0, "pre_stale2");
    apply_sample(8'd200, 8'd200, 1'b1, 1'b1, 1'b0, "pre_stale3");
    repeat (48) @(negedge clk_1MHz);
    check("stale before timeout", stale, 0);
    check("safe before timeout", state_safe, 1);
    @(negedge clk_1MHz);
    check("stale at timeout", stale, 1);
    check("stale state_safe", state_safe, 0);
    check("stale win_full", win_full, 0);
    check("stale avg_out hold", avg_out, 200);
    check("stale avg_valid", avg_valid, 0);
    @(negedge clk_1MHz);
    check("stale held", stale, 1);
    $display("stale event: stale=%0b safe=%0b full=%0b avg=%0d", stale, state_safe, win_full, avg_out);
    apply_sample(8'd200, 8'd50,  1'b0, 1'b0, 1'b0, "post_stale0");
    apply_sample(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, "post_stale1");
    apply_sample(8'd200, 8'd150, 1'b0, 1'b0, 1'b0, "post_stale2");
    apply_sample(8'd200, 8'd200, 1'b1, 1'b1, 1'b0, "post_stale3");

    // Collision: sample lands on the cycle that would trigger the flush.
    repeat (48) @(negedge clk_1MHz);
    check("collision pre stale", stale, 0);
    check("collision pre win_full", win_full, 1);
    apply_sample(8'd100, 8'd175, 1'b1, 1'b1, 1'b0, "collision");

    // Async reset with a sample in flight.
    valid_in = 1'b1;
    data_in  = 8'd0;
    @(posedge clk_1MHz);
    #1;
    check("inflight avg_valid", avg_valid, 1);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    #1;
    check("async avg_out", avg_out, 0);
    check("async avg_valid", avg_valid, 0);
    check("async win_full", win_full, 0);
    check("async state_safe", state_safe, 0);
    check("async alarm_change", alarm_change, 0);
    check("async stale", stale, 0);
    $display("async reset: avg=%0d valid=%0b safe=%0b", avg_out, avg_valid, state_safe);
    @(negedge clk_1MHz);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_1MHz);
      check($sformatf("post_rst%0d avg_valid", k), avg_valid, 0);
      check($sformatf("post_rst%0d alarm_change", k), alarm_change, 0);
      check($sformatf("post_rst%0d avg_out", k), avg_out, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
